dmem_arbiter: RTL and testbench

Shares the single-port data memory between the CPU MEM stage and a debug/loader port. The CPU has priority. The debug port gets the memory when the CPU is idle, or by force after a starvation limit; in that case the CPU MEM stage is held with `cpu_stall` for one cycle. The block sits between the `ARM_RISC` MEM-stage memory signals and `DATA_MEM`, and is transparent (combinational pass-through) whenever the CPU owns the bus.

---
 rtl/arm_pkg.sv | 14 +
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the data-memory arbiter: default bus widths and
// the arbiter state encoding.
package arm_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        ST_CPU = 2'd0,
        ST_DBG = 2'd1,
        ST_ACK = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (priority,
// zero-latency pass-through) and a debug/loader port with starvation forcing.
module dmem_arbiter
    import arm_pkg::*;
#(
    parameter int ADDR_W       = arm_pkg::ADDR_W,
    parameter int DATA_W       = arm_pkg::DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

    arb_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
    logic              dbg_ack_reg, dbg_ack_next;
    logic [DATA_W-1:0] dbg_rdata_reg, dbg_rdata_next;

    logic cpu_act;
    logic dbg_sel;

    assign cpu_act = cpu_read | cpu_write;
    // Reset hands the bus back to the CPU so a debug access in flight is dropped.
    assign dbg_sel = (state_reg == ST_DBG) && !reset;

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
        cpu_stall = 1'b0;
        if (dbg_sel) begin
            mem_read  = !dbg_we;
            mem_write = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            cpu_rdata = '0;
            cpu_stall = cpu_act;
        end else if (!reset) begin
            mem_read  = cpu_read;
            mem_write = cpu_write;
        end
    end

    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        dbg_ack_next    = 1'b0;
        dbg_rdata_next  = dbg_rdata_reg;
        case (state_reg)
            ST_CPU: begin
                if (dbg_req && (!cpu_act || starve_cnt_reg == LIMIT_CNT)) begin
                    state_next      = ST_DBG;
                    starve_cnt_next = '0;
                end else if (dbg_req && cpu_act && starve_cnt_reg != LIMIT_CNT) begin
                    starve_cnt_next = starve_cnt_reg + 1'b1;
                end
            end
            ST_DBG: begin
                state_next   = ST_ACK;
                dbg_ack_next = 1'b1;
                if (!dbg_we) begin
                    dbg_rdata_next = mem_rdata;
                end
            end
            // The ack cycle is always CPU-owned, guaranteeing a gap between debug accesses.
            ST_ACK:  state_next = ST_CPU;
            default: state_next = ST_CPU;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_CPU;
            starve_cnt_reg <= '0;
            dbg_ack_reg    <= 1'b0;
            dbg_rdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            dbg_ack_reg    <= dbg_ack_next;
            dbg_rdata_reg  <= dbg_rdata_next;
        end
    end

    assign dbg_ack   = dbg_ack_reg;
    assign dbg_rdata = dbg_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int LIMIT = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [63:0] dbg_addr, dbg_wdata;
    logic        dbg_ack;
    logic [63:0] dbg_rdata;
    logic        mem_read, mem_write;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Single-port data memory: combinational read, write on the rising edge.
    logic [63:0] env_mem [32];
    assign mem_rdata = env_mem[mem_addr[7:3]];
    always @(posedge clock) if (mem_write) env_mem[mem_addr[7:3]] <= mem_wdata;

    // Reference model: memory contents plus where the debug transaction stands.
    logic [63:0] m_mem [32];
    logic [63:0] m_dbg_rdata;
    bit          m_grant;   // debug access occupies the memory this cycle
    bit          m_ack;     // ack cycle, CPU-owned
    int          m_wait;    // blocked request cycles so far

    int n_cmp = 0;
    int n_bad = 0;

    logic        obs_stall, obs_ack, obs_mread, obs_mwrite;
    logic [63:0] obs_crd;

    function automatic int idx(input logic [63:0] a);
        return int'(a[7:3]);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check every output against the model, then advance the model.
    task automatic cycle();
        logic        act;
        bit          n_grant, n_ack;
        int          n_wait;
        logic [63:0] n_rd;
        #1;
        act = cpu_read | cpu_write;
        obs_stall = cpu_stall; obs_ack = dbg_ack; obs_crd = cpu_rdata;
        obs_mread = mem_read;  obs_mwrite = mem_write;
        check("dbg_ack", {63'd0, dbg_ack}, {63'd0, m_ack});
        check("dbg_rdata", dbg_rdata, m_dbg_rdata);
        if (reset) begin
            check("rst_mem_read", {63'd0, mem_read}, 64'd0);
            check("rst_mem_write", {63'd0, mem_write}, 64'd0);
            check("rst_cpu_stall", {63'd0, cpu_stall}, 64'd0);
        end else if (m_grant) begin
            check("dbg_mem_read", {63'd0, mem_read}, {63'd0, !dbg_we});
            check("dbg_mem_write", {63'd0, mem_write}, {63'd0, dbg_we});
            check("dbg_mem_addr", mem_addr, dbg_addr);
            if (dbg_we) check("dbg_mem_wdata", mem_wdata, dbg_wdata);
            check("dbg_cpu_stall", {63'd0, cpu_stall}, {63'd0, act});
            check("dbg_cpu_rdata", cpu_rdata, 64'd0);
        end else begin
            check("cpu_mem_read", {63'd0, mem_read}, {63'd0, cpu_read});
            check("cpu_mem_write", {63'd0, mem_write}, {63'd0, cpu_write});
            check("cpu_mem_addr", mem_addr, cpu_addr);
            if (cpu_write) check("cpu_mem_wdata", mem_wdata, cpu_wdata);
            check("cpu_stall", {63'd0, cpu_stall}, 64'd0);
            check("cpu_rdata", cpu_rdata, m_mem[idx(cpu_addr)]);
        end

        n_grant = 1'b0; n_ack = 1'b0; n_wait = m_wait; n_rd = m_dbg_rdata;
        if (reset) begin
            n_wait = 0;
            n_rd   = '0;
        end else if (m_grant) begin
            n_ack = 1'b1;
            if (dbg_we) m_mem[idx(dbg_addr)] = dbg_wdata;
            else        n_rd = m_mem[idx(dbg_addr)];
            $display("t=%0t debug %s addr=%h data=%h", $time, dbg_we ? "write" : "read ",
                     dbg_addr, dbg_we ? dbg_wdata : m_mem[idx(dbg_addr)]);
        end else begin
            if (cpu_write) m_mem[idx(cpu_addr)] = cpu_wdata;
            if (!m_ack && dbg_req) begin
                if (!act || m_wait >= LIMIT) begin
                    n_grant = 1'b1;
                    n_wait  = 0;
                end else if (m_wait < LIMIT) begin
                    n_wait = m_wait + 1;
                end
            end
        end
        @(posedge clock);
        m_grant = n_grant; m_ack = n_ack; m_wait = n_wait; m_dbg_rdata = n_rd;
        #1;
    endtask

    task automatic idle();
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    initial begin
        int stall_cnt, stall_at, ack_at, a1, ack1, a2;
        bit req_active;
        for (int i = 0; i < 32; i++) begin
            env_mem[i] = '0;
            m_mem[i]   = '0;
        end
        m_grant = 1'b0; m_ack = 1'b0; m_wait = 0; m_dbg_rdata = '0;
        idle();
        reset = 1'b1;
        cycle();
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 64'h8;
        cycle();
        idle();
        reset = 1'b0;
        check("reset_dbg_rdata", dbg_rdata, 64'd0);

        // CPU write then read
        cpu_write = 1'b1; cpu_addr = 64'h10; cpu_wdata = 64'hDEAD_BEEF;
        cycle();
        cpu_write = 1'b0; cpu_read = 1'b1;
        cycle();
        check("cpu_read_back", obs_crd, 64'hDEAD_BEEF);
        check("cpu_read_nostall", {63'd0, obs_stall}, 64'd0);
        idle();

        // Debug read while CPU idle: access in N+1, ack in N+2
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h10;
        cycle();
        check("idle_dbg_mem_read", {63'd0, mem_read}, 64'd1);
        cycle();
        check("idle_dbg_ack", {63'd0, dbg_ack}, 64'd1);
        check("idle_dbg_rdata", dbg_rdata, 64'hDEAD_BEEF);
        dbg_req = 1'b0;
        cycle();
        cycle();

        // Starvation: CPU reads every cycle, request held
        stall_cnt = 0; stall_at = -1; ack_at = -1;
        cpu_read = 1'b1; cpu_addr = 64'h18;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h10;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (obs_stall) begin stall_cnt++; stall_at = i; end
            if (obs_ack && ack_at < 0) begin ack_at = i; dbg_req = 1'b0; end
        end
        check("starve_stall_count", 64'(stall_cnt), 64'd1);
        check("starve_stall_cycle", 64'(stall_at), 64'd9);
        check("starve_ack_cycle", 64'(ack_at), 64'd10);
        idle();
        cycle();

        // Back-to-back debug with request held through the first ack
        a1 = -1; ack1 = -1; a2 = -1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h10;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (obs_mread && !cpu_read) begin
                if (a1 < 0) a1 = i; else if (a2 < 0) a2 = i;
            end
            if (obs_ack && ack1 < 0) ack1 = i;
            if (obs_ack && a2 >= 0) dbg_req = 1'b0;
        end
        check("b2b_first_access", 64'(a1), 64'd1);
        check("b2b_first_ack", 64'(ack1), 64'd2);
        check("b2b_second_access", 64'(a2), 64'd4);
        idle();
        cycle();

        // Debug write then CPU read
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 64'h20; dbg_wdata = 64'h1234;
        cycle();
        cycle();
        dbg_req = 1'b0;
        cycle();
        cpu_read = 1'b1; cpu_addr = 64'h20;
        cycle();
        check("dbgwr_cpu_read", obs_crd, 64'h1234);
        idle();

        // Reset while a debug write is in ST_DBG
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 64'h30; dbg_wdata = 64'h55;
        cycle();
        reset = 1'b1;
        cycle();
        check("rst_dbg_write_dropped", {63'd0, obs_mwrite}, 64'd0);
        reset = 1'b0; dbg_req = 1'b0;
        cycle();
        check("rst_dbg_no_ack", {63'd0, obs_ack}, 64'd0);
        cpu_read = 1'b1; cpu_addr = 64'h30;
        cycle();
        check("rst_addr30_unchanged", obs_crd, 64'd0);
        idle();
        cycle();

        // Randomized traffic
        req_active = 1'b0;
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 59) == 0);
            cpu_read  = $urandom_range(0, 1) == 1;
            cpu_write = $urandom_range(0, 2) == 0;
            cpu_addr  = {56'd0, 5'($urandom_range(0, 31)), 3'b000};
            cpu_wdata = {$urandom, $urandom};
            if (req_active && m_ack && $urandom_range(0, 1) == 0) begin
                req_active = 1'b0;
                dbg_req    = 1'b0;
            end else if ((req_active && m_ack) || (!req_active && $urandom_range(0, 3) == 0)) begin
                req_active = 1'b1;
                dbg_req    = 1'b1;
                dbg_we     = $urandom_range(0, 1) == 1;
                dbg_addr   = {56'd0, 5'($urandom_range(0, 31)), 3'b000};
                dbg_wdata  = {$urandom, $urandom};
            end
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
